battle_turn_ctrl: RTL and testbench

//  Turn sequencer for the battleship game: IDLE -> ship placement -> alternating player/PC turns -> game over.

---
 rtl/battle_pkg.sv | 34 +++
 rtl/battle_turn_ctrl_if.sv | 35 +++
 rtl/turn_timer.sv | 45 ++++
 rtl/battle_turn_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_battle_turn_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/battle_pkg.sv
// Shared types for the battleship turn sequencer: state encoding and the debug display map.
package battle_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PLACE  = 4'd1,
    ST_PTURN  = 4'd2,
    ST_PFIRE  = 4'd3,
    ST_CHKPC  = 4'd4,
    ST_PCWAIT = 4'd5,
    ST_PCFIRE = 4'd6,
    ST_OVER   = 4'd7,
    ST_CHKPL  = 4'd8
  } state_t;

  // CHKPL is a one-cycle bookkeeping state, so it shows up as the PC-fire code.
  function automatic logic [2:0] state_disp(input state_t s);
    logic [2:0] code;
    case (s)
      ST_IDLE:   code = 3'b000;
      ST_PLACE:  code = 3'b001;
      ST_PTURN:  code = 3'b010;
      ST_PFIRE:  code = 3'b011;
      ST_CHKPC:  code = 3'b100;
      ST_PCWAIT: code = 3'b101;
      ST_PCFIRE: code = 3'b110;
      ST_CHKPL:  code = 3'b110;
      ST_OVER:   code = 3'b111;
      default:   code = 3'b000;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/battle_turn_ctrl_if.sv
// Signal bundle between the turn sequencer and the input, board, attack and VGA blocks.
interface battle_turn_ctrl_if #(
  parameter int SHIP_W = 3,
  parameter int HP_W   = 3,
  parameter int CNT_W  = 4,
  parameter int TURN_W = 6
);
  logic              attack;
  logic              tick;
  logic [SHIP_W-1:0] ships_left;
  logic [HP_W-1:0]   hp_pc;
  logic [HP_W-1:0]   hp_player;
  logic              en_put_barcos;
  logic              en_move;
  logic              en_cont_seg;
  logic              en_player_attack;
  logic              en_pc_attack;
  logic [CNT_W-1:0]  seconds_left;
  logic [TURN_W-1:0] turn_count;
  logic              game_over;
  logic              player_won;
  logic [2:0]        state_o;

  modport master (
    output attack, tick, ships_left, hp_pc, hp_player,
    input  en_put_barcos, en_move, en_cont_seg, en_player_attack, en_pc_attack,
           seconds_left, turn_count, game_over, player_won, state_o
  );

  modport slave (
    input  attack, tick, ships_left, hp_pc, hp_player,
    output en_put_barcos, en_move, en_cont_seg, en_player_attack, en_pc_attack,
           seconds_left, turn_count, game_over, player_won, state_o
  );
endinterface

// File: rtl/turn_timer.sv
// Loadable per-turn seconds down-counter; holds at one and flags expiry on the final tick.
module turn_timer #(
  parameter int CNT_W    = 4,
  parameter int LOAD_VAL = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             expire
);
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_one_s;

  assign at_one_s = (count_q == CNT_W'(1));
  assign expire   = en && tick && at_one_s;
  assign count    = count_q;

  // Clear beats load beats decrement; the last second is held rather than counted to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = CNT_W'(LOAD_VAL);
    end else if (en && tick && !at_one_s && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/battle_turn_ctrl.sv
// Battleship turn sequencer: placement, alternating player/PC turns, win/lose and restart.
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int SHIP_W       = 3,
  parameter int HP_W         = 3,
  parameter int TURN_SECONDS = 15,
  parameter int PC_DELAY     = 50,
  parameter int TURN_W       = 6
) (
  input logic               clk,
  input logic               reset,
  battle_turn_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TURN_SECONDS + 1);
  localparam int DLY_W = (PC_DELAY > 0) ? $clog2(PC_DELAY + 1) : 1;
  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(PC_DELAY);
  localparam logic [TURN_W-1:0] TURN_MAX = {TURN_W{1'b1}};

  state_t            state_q, state_d;
  logic              attack_q, arm_q, rise_s;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              won_q, won_d;
  logic              tmr_clr_s, tmr_load_s, tmr_en_s, tmr_expire_s;
  logic [CNT_W-1:0]  sec_s;
  logic              put_q, put_d, move_q, move_d, cont_q, cont_d;
  logic              pa_q, pa_d, pca_q, pca_d, over_q, over_d;
  logic [2:0]        disp_q, disp_d;

  // arm_q masks the first cycle after reset so a button held through reset is not a press.
  assign rise_s   = bus.attack && !attack_q && arm_q;
  assign tmr_en_s = (state_q == ST_PTURN) && !rise_s;

  turn_timer #(.CNT_W(CNT_W), .LOAD_VAL(TURN_SECONDS)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr_s),
    .load   (tmr_load_s),
    .en     (tmr_en_s),
    .tick   (bus.tick),
    .count  (sec_s),
    .expire (tmr_expire_s)
  );

  // Next-state, PC delay count, round count and winner flag.
  always_comb begin
    state_d    = state_q;
    dly_d      = '0;
    turn_d     = turn_q;
    won_d      = won_q;
    tmr_clr_s  = 1'b0;
    tmr_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) state_d = ST_PLACE;
        else        state_d = ST_IDLE;
      end
      ST_PLACE: begin
        if (bus.ships_left == SHIP_W'(0)) begin
          state_d    = ST_PTURN;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_PLACE;
        end
      end
      ST_PTURN: begin
        if (rise_s)            state_d = ST_PFIRE;
        else if (tmr_expire_s) state_d = ST_PCWAIT;
        else                   state_d = ST_PTURN;
      end
      ST_PFIRE: state_d = ST_CHKPC;
      ST_CHKPC: begin
        if (bus.hp_pc == HP_W'(0)) begin
          state_d = ST_OVER;
          won_d   = 1'b1;
        end else begin
          state_d = ST_PCWAIT;
        end
      end
      ST_PCWAIT: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_PCFIRE;
        end else begin
          state_d = ST_PCWAIT;
          dly_d   = dly_q + DLY_W'(1);
        end
      end
      ST_PCFIRE: state_d = ST_CHKPL;
      ST_CHKPL: begin
        if (bus.hp_player == HP_W'(0)) begin
          state_d = ST_OVER;
          won_d   = 1'b0;
        end else begin
          state_d    = ST_PTURN;
          tmr_load_s = 1'b1;
          turn_d     = (turn_q == TURN_MAX) ? turn_q : turn_q + TURN_W'(1);
        end
      end
      ST_OVER: begin
        if (rise_s) begin
          state_d   = ST_IDLE;
          won_d     = 1'b0;
          turn_d    = '0;
          tmr_clr_s = 1'b1;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        won_d     = 1'b0;
        turn_d    = '0;
        tmr_clr_s = 1'b1;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered enables line up with the state.
  always_comb begin
    put_d  = 1'b0;
    move_d = 1'b0;
    cont_d = 1'b0;
    pa_d   = 1'b0;
    pca_d  = 1'b0;
    over_d = 1'b0;
    disp_d = state_disp(state_d);
    case (state_d)
      ST_PLACE:  begin put_d = 1'b1; move_d = 1'b1; end
      ST_PTURN:  begin move_d = 1'b1; cont_d = 1'b1; end
      ST_PFIRE:  pa_d   = 1'b1;
      ST_PCFIRE: pca_d  = 1'b1;
      ST_OVER:   over_d = 1'b1;
      default:   put_d  = 1'b0;
    endcase
  end

  // State, edge detector, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      attack_q <= 1'b0;
      arm_q    <= 1'b0;
      dly_q    <= '0;
      turn_q   <= '0;
      won_q    <= 1'b0;
      put_q    <= 1'b0;
      move_q   <= 1'b0;
      cont_q   <= 1'b0;
      pa_q     <= 1'b0;
      pca_q    <= 1'b0;
      over_q   <= 1'b0;
      disp_q   <= 3'b000;
    end else begin
      state_q  <= state_d;
      attack_q <= bus.attack;
      arm_q    <= 1'b1;
      dly_q    <= dly_d;
      turn_q   <= turn_d;
      won_q    <= won_d;
      put_q    <= put_d;
      move_q   <= move_d;
      cont_q   <= cont_d;
      pa_q     <= pa_d;
      pca_q    <= pca_d;
      over_q   <= over_d;
      disp_q   <= disp_d;
    end
  end

  assign bus.en_put_barcos    = put_q;
  assign bus.en_move          = move_q;
  assign bus.en_cont_seg      = cont_q;
  assign bus.en_player_attack = pa_q;
  assign bus.en_pc_attack     = pca_q;
  assign bus.seconds_left     = sec_s;
  assign bus.turn_count       = turn_q;
  assign bus.game_over        = over_q;
  assign bus.player_won       = won_q;
  assign bus.state_o          = disp_q;
endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Randomized games against a rule-level model; shot pulses and game-over are scoreboarded.
module tb_battle_turn_ctrl;
  localparam int SHIP_W = 3;
  localparam int HP_W   = 3;
  localparam int TS     = 3;
  localparam int PD     = 4;
  localparam int TW     = 2;
  localparam int CNT_W  = $clog2(TS + 1);
  localparam int TMAX   = (1 << TW) - 1;

  typedef struct { int kind; int at; int val; } exp_t;  // kind 0 player shot, 1 PC shot, 2 game over

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   go_prev = 1'b0;

  battle_turn_ctrl_if #(.SHIP_W(SHIP_W), .HP_W(HP_W), .CNT_W(CNT_W), .TURN_W(TW)) bus ();

  battle_turn_ctrl #(.SHIP_W(SHIP_W), .HP_W(HP_W), .TURN_SECONDS(TS), .PC_DELAY(PD), .TURN_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int at, input int val);
    exp_t e;
    e.kind = kind; e.at = at; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic mon_evt(input int kind, input int val);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event kind %0d val %0d at cycle %0d, expected none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
      chk("event_value", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (bus.en_player_attack) mon_evt(0, int'(bus.seconds_left));
    if (bus.en_pc_attack) mon_evt(1, int'(bus.turn_count));
    if (bus.game_over && !go_prev) mon_evt(2, int'(bus.player_won));
    go_prev = bus.game_over;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic play_game(input int min_rounds, input bit do_reset);
    int  sec, turns, rounds, d, e, p, k, hp;
    bit  timeout, done, won;
    bus.attack = 1'b0; bus.tick = 1'b0;
    step();
    bus.ships_left = SHIP_W'($urandom_range(1, 7));
    bus.attack = 1'b1;
    step();
    bus.attack = 1'b0;
    chk("place_en_put", int'(bus.en_put_barcos), 1);
    chk("place_state", int'(bus.state_o), 1);
    idle($urandom_range(1, 3));
    bus.ships_left = '0;
    step();
    sec = TS; turns = 0; rounds = 0; done = 1'b0; won = 1'b0; e = 0;
    while (!done) begin
      chk("turn_seconds_load", int'(bus.seconds_left), TS);
      chk("turn_state", int'(bus.state_o), 2);
      chk("turn_count", int'(bus.turn_count), turns);
      timeout = ($urandom_range(0, 3) == 0);
      k = timeout ? TS : int'($urandom_range(0, TS - 1));
      for (int i = 0; i < k; i++) begin
        idle($urandom_range(0, 2));
        d = cyc;
        bus.tick = 1'b1; step(); bus.tick = 1'b0;
        if (sec == 1) e = d + 1;
        else begin sec--; chk("seconds_dec", int'(bus.seconds_left), sec); end
      end
      if (!timeout) begin
        idle($urandom_range(0, 2));
        hp = ($urandom_range(0, 2) == 0 && rounds >= min_rounds) ? 0 : int'($urandom_range(1, 7));
        bus.hp_pc = HP_W'(hp);
        bus.attack = 1'b1;
        bus.tick = (sec == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        d = cyc;
        push_exp(0, d + 1, sec);
        if (hp == 0) push_exp(2, d + 3, 1);
        step();
        bus.attack = 1'b0; bus.tick = 1'b0;
        idle(2);
        if (hp == 0) begin won = 1'b1; done = 1'b1; end
        else e = d + 3;
      end
      if (!done) begin
        if (do_reset) begin
          idle(2);
          reset = 1'b0;
          #1;
          chk("midreset_state", int'(bus.state_o), 0);
          chk("midreset_pc_attack", int'(bus.en_pc_attack), 0);
          chk("midreset_seconds", int'(bus.seconds_left), 0);
          step();
          reset = 1'b1;
          idle(2);
          chk("after_reset_idle", int'(bus.state_o), 0);
          return;
        end
        p = e + PD + 1;
        push_exp(1, p, turns);
        while (cyc < p - 1) begin
          bus.tick = 1'($urandom_range(0, 1));
          bus.attack = 1'($urandom_range(0, 1));
          bus.hp_pc = HP_W'($urandom_range(0, 7));
          bus.hp_player = HP_W'($urandom_range(0, 7));
          step();
        end
        bus.tick = 1'b0; bus.attack = 1'b0;
        hp = ($urandom_range(0, 2) == 0 && rounds >= min_rounds) ? 0 : int'($urandom_range(1, 7));
        bus.hp_player = HP_W'(hp);
        if (hp == 0) push_exp(2, p + 2, 0);
        while (cyc < p + 2) step();
        if (hp == 0) begin won = 1'b0; done = 1'b1; end
        else begin
          rounds++;
          turns = (turns < TMAX) ? turns + 1 : TMAX;
          sec = TS;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      bus.tick = 1'($urandom_range(0, 1));
      bus.hp_pc = HP_W'($urandom_range(0, 7));
      bus.hp_player = HP_W'($urandom_range(0, 7));
      step();
    end
    bus.tick = 1'b0;
    chk("over_flag", int'(bus.game_over), 1);
    chk("over_winner", int'(bus.player_won), int'(won));
    chk("over_state", int'(bus.state_o), 7);
    chk("over_turns", int'(bus.turn_count), turns);
    chk("over_no_move", int'(bus.en_move), 0);
    bus.attack = 1'b1;
    step();
    bus.attack = 1'b0;
    chk("restart_state", int'(bus.state_o), 0);
    chk("restart_turns", int'(bus.turn_count), 0);
    chk("restart_seconds", int'(bus.seconds_left), 0);
    chk("restart_winner", int'(bus.player_won), 0);
    chk("restart_over", int'(bus.game_over), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.attack = 1'b1; bus.tick = 1'b1;
    bus.ships_left = '0; bus.hp_pc = '0; bus.hp_player = '0;
    reset = 1'b0;
    idle(3);
    chk("reset_state", int'(bus.state_o), 0);
    chk("reset_outputs", int'({bus.en_put_barcos, bus.en_move, bus.en_cont_seg,
                               bus.en_player_attack, bus.en_pc_attack, bus.game_over, bus.player_won}), 0);
    chk("reset_seconds", int'(bus.seconds_left), 0);
    chk("reset_turns", int'(bus.turn_count), 0);
    bus.tick = 1'b0;
    reset = 1'b1;
    idle(4);
    chk("held_attack_idle", int'(bus.state_o), 0);
    chk("held_attack_no_place", int'(bus.en_put_barcos), 0);
    play_game(5, 1'b0);
    for (int g = 1; g < 8; g++) play_game((g == 3) ? 1 : 0, g == 3);
    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
